// File: rtl/score_keeper.sv
// Game-state and scoring stage feeding the score renderer: edge-detects goal,
// snitch and start, keeps a saturating score, a match countdown and a high score.
module score_keeper #(
  parameter int GOAL_POINTS    = 10,
  parameter int SNITCH_POINTS  = 150,
  parameter int MAX_SCORE      = 999,
  parameter int GAME_SECONDS   = 120,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        goal,
  input  logic        snitch_caught,
  input  logic        frame_tick,
  output logic [13:0] score,
  output logic        playing_reg,
  output logic        game_over,
  output logic [13:0] high_score,
  output logic [7:0]  time_left,
  output logic        score_pulse
);

  localparam logic [14:0] GOAL_P   = 15'(GOAL_POINTS);
  localparam logic [14:0] SNITCH_P = 15'(SNITCH_POINTS);
  localparam logic [13:0] MAX_S    = 14'(MAX_SCORE);
  localparam logic [7:0]  GAME_S   = 8'(GAME_SECONDS);
  localparam logic [7:0]  FPS_M1   = 8'(FRAMES_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_start_q, r_goal_q, r_snitch_q;
  logic [13:0] r_score, r_high;
  logic [7:0]  r_time_left, r_frame_cnt;
  logic        r_pulse;

  logic        w_rise_start, w_rise_goal, w_rise_snitch;
  logic        w_playing, w_begin, w_tick_wrap, w_expire;
  logic [14:0] w_add, w_sum;
  logic [13:0] w_next_score;

  assign w_rise_start  = start & ~r_start_q;
  assign w_rise_goal   = goal & ~r_goal_q;
  assign w_rise_snitch = snitch_caught & ~r_snitch_q;

  assign w_playing   = (r_state == S_PLAY);
  assign w_begin     = !w_playing && w_rise_start;
  assign w_tick_wrap = w_playing && frame_tick && (r_frame_cnt == FPS_M1);
  assign w_expire    = w_tick_wrap && (r_time_left == 8'd1);

  // 15-bit sum so the largest possible add cannot wrap before the clamp
  assign w_add        = (w_rise_goal ? GOAL_P : 15'd0) + (w_rise_snitch ? SNITCH_P : 15'd0);
  assign w_sum        = {1'b0, r_score} + w_add;
  assign w_next_score = (w_sum > {1'b0, MAX_S}) ? MAX_S : w_sum[13:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q  <= 1'b1;
      r_goal_q   <= 1'b1;
      r_snitch_q <= 1'b1;
    end else begin
      r_start_q  <= start;
      r_goal_q   <= goal;
      r_snitch_q <= snitch_caught;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise_start) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_rise_snitch || w_expire) w_state_nxt = S_OVER;
      S_OVER:  if (w_rise_start) w_state_nxt = S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score     <= '0;
      r_time_left <= GAME_S;
      r_frame_cnt <= '0;
      r_pulse     <= 1'b0;
    end else if (w_begin) begin
      r_score     <= '0;
      r_time_left <= GAME_S;
      r_frame_cnt <= '0;
      r_pulse     <= (r_score != 14'd0);
    end else if (w_playing) begin
      r_score <= w_next_score;
      r_pulse <= (w_next_score != r_score);
      if (frame_tick) r_frame_cnt <= w_tick_wrap ? 8'd0 : r_frame_cnt + 8'd1;
      if (w_tick_wrap && r_time_left != 8'd0) r_time_left <= r_time_left - 8'd1;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  // Score is frozen in OVER, so comparing there captures the final score
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_high <= '0;
    else if (r_state == S_OVER && r_score > r_high) r_high <= r_score;
  end

  assign score       = r_score;
  assign time_left   = r_time_left;
  assign high_score  = r_high;
  assign score_pulse = r_pulse;
  assign playing_reg = w_playing;
  assign game_over   = (r_state == S_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short match (2 frames/s, 3 s).
module tb_score_keeper;
  logic        clk = 1'b0, reset, start, goal, snitch_caught, frame_tick;
  logic [13:0] score, high_score;
  logic [7:0]  time_left;
  logic        playing_reg, game_over, score_pulse;
  int          n_tests = 0, n_fail = 0;

  score_keeper #(.GOAL_POINTS(10), .SNITCH_POINTS(150), .MAX_SCORE(999),
                 .GAME_SECONDS(3), .FRAMES_PER_SEC(2)) dut (
    .clk(clk), .reset(reset), .start(start), .goal(goal),
    .snitch_caught(snitch_caught), .frame_tick(frame_tick),
    .score(score), .playing_reg(playing_reg), .game_over(game_over),
    .high_score(high_score), .time_left(time_left), .score_pulse(score_pulse));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_goal(input logic [13:0] exp, input logic exp_pulse, input string tag);
    goal = 1'b1; step();
    chk({tag, "_score"}, score, exp);
    chk({tag, "_pulse"}, score_pulse, exp_pulse);
    goal = 1'b0; step();
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; goal = 1'b0; snitch_caught = 1'b0; frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", score, 0);
    chk("rst_time", time_left, 3);
    chk("rst_play", playing_reg, 0);
    chk("rst_over", game_over, 0);
    chk("rst_high", high_score, 0);
    chk("rst_pulse", score_pulse, 0);
    reset = 1'b0;

    // 1: start held through reset gives no event
    repeat (5) step();
    chk("t1_held_play", playing_reg, 0);
    start = 1'b0; step();
    do_start();
    chk("t1_play", playing_reg, 1);
    chk("t1_score", score, 0);
    chk("t1_time", time_left, 3);
    chk("t1_pulse0", score_pulse, 0);

    // 2: goals, the third one held for 50 cycles
    do_goal(10, 1, "t2_g1");
    chk("t2_pulse_clr", score_pulse, 0);
    do_goal(20, 1, "t2_g2");
    goal = 1'b1; step();
    chk("t2_g3_score", score, 30);
    chk("t2_g3_pulse", score_pulse, 1);
    repeat (49) step();
    chk("t2_hold_score", score, 30);
    chk("t2_hold_pulse", score_pulse, 0);
    goal = 1'b0; step();

    // 3: goal + snitch together
    goal = 1'b1; snitch_caught = 1'b1; step();
    chk("t3_score", score, 190);
    chk("t3_over", game_over, 1);
    chk("t3_play", playing_reg, 0);
    chk("t3_pulse", score_pulse, 1);
    goal = 1'b0; snitch_caught = 1'b0; step();
    chk("t3_high", high_score, 190);
    do_goal(190, 0, "t3_ign");
    chk("t3_still_over", game_over, 1);

    // 4: timer expiry with a goal on the final tick
    do_start();
    chk("t4_play", playing_reg, 1);
    chk("t4_score", score, 0);
    chk("t4_restart_pulse", score_pulse, 1);
    chk("t4_time0", time_left, 3);
    for (int i = 1; i <= 6; i++) begin
      frame_tick = 1'b1;
      if (i == 6) goal = 1'b1;
      step();
      frame_tick = 1'b0; goal = 1'b0;
      chk($sformatf("t4_time_t%0d", i), time_left, 8'(3 - i / 2));
      if (i < 6) chk($sformatf("t4_play_t%0d", i), playing_reg, 1);
      step();
    end
    chk("t4_over", game_over, 1);
    chk("t4_score_end", score, 10);
    chk("t4_high", high_score, 190);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    chk("t4_time_hold", time_left, 0);

    // 5: saturation
    do_start();
    chk("t5_play", playing_reg, 1);
    for (int i = 0; i < 99; i++) begin
      goal = 1'b1; step(); goal = 1'b0; step();
    end
    chk("t5_990", score, 990);
    do_goal(999, 1, "t5_sat");
    do_goal(999, 0, "t5_sat2");
    snitch_caught = 1'b1; step(); snitch_caught = 1'b0;
    chk("t5_sn_score", score, 999);
    chk("t5_sn_pulse", score_pulse, 0);
    chk("t5_sn_over", game_over, 1);
    step();
    chk("t5_high", high_score, 999);

    // 6: asynchronous reset mid-match
    do_start();
    for (int i = 0; i < 4; i++) begin
      goal = 1'b1; step(); goal = 1'b0; step();
    end
    repeat (2) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    end
    chk("t6_pre_score", score, 40);
    chk("t6_pre_time", time_left, 2);
    #3 reset = 1'b1;
    #1;
    chk("t6_score", score, 0);
    chk("t6_time", time_left, 3);
    chk("t6_play", playing_reg, 0);
    chk("t6_over", game_over, 0);
    chk("t6_high", high_score, 0);
    chk("t6_pulse", score_pulse, 0);
    step(); reset = 1'b0;
    repeat (3) step();
    chk("t6_idle", playing_reg, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
